// File: rtl/sad_trigger_qualifier.sv
// SAD trigger qualifier: turns raw SAD-matcher match pulses into a qualified
// capture trigger. Applies arming, Nth-match counting, pulse width, holdoff
// and single-shot rules, and keeps sticky status and score registers.
module sad_trigger_qualifier #(
  parameter int pSCORE_WIDTH   = 32,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 8,
  parameter int pWIDTH_WIDTH   = 8
) (
  input  logic                      clk_adc,
  input  logic                      reset_n,
  input  logic                      arm_i,
  input  logic                      sad_match_i,
  input  logic [pSCORE_WIDTH-1:0]   sad_score_i,
  input  logic [pCOUNT_WIDTH-1:0]   cfg_match_count,
  input  logic [pWIDTH_WIDTH-1:0]   cfg_trigger_width,
  input  logic [pHOLDOFF_WIDTH-1:0] cfg_holdoff,
  input  logic                      cfg_single_shot,
  output logic                      trigger_o,
  output logic                      armed_o,
  output logic                      triggered_o,
  output logic [pCOUNT_WIDTH-1:0]   match_cnt_o,
  output logic [7:0]                missed_o,
  output logic [pSCORE_WIDTH-1:0]   match_score_o,
  output logic [pSCORE_WIDTH-1:0]   best_score_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [pCOUNT_WIDTH-1:0]   C_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pWIDTH_WIDTH-1:0]   W_ONE = {{(pWIDTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pHOLDOFF_WIDTH-1:0] H_ONE = {{(pHOLDOFF_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic                      arm_prev_q, arm_prev_d;
  logic                      trigger_q, trigger_d;
  logic                      armed_q, armed_d;
  logic                      triggered_q, triggered_d;
  logic [pCOUNT_WIDTH-1:0]   match_cnt_q, match_cnt_d;
  logic [7:0]                missed_q, missed_d;
  logic [pSCORE_WIDTH-1:0]   match_score_q, match_score_d;
  logic [pSCORE_WIDTH-1:0]   best_score_q, best_score_d;
  // Remaining trigger-high cycles after the current one.
  logic [pWIDTH_WIDTH-1:0]   width_cnt_q, width_cnt_d;
  // Holdoff length captured when the pulse started.
  logic [pHOLDOFF_WIDTH-1:0] hold_len_q, hold_len_d;
  // Remaining holdoff cycles after the current one.
  logic [pHOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;

  logic                      arm_rise;
  logic [pCOUNT_WIDTH-1:0]   eff_count;
  logic [pWIDTH_WIDTH-1:0]   eff_width_m1;
  logic [pCOUNT_WIDTH:0]     cnt_inc;
  logic                      fire_hit;
  logic [7:0]                missed_sat;

  // Derived helpers: arm edge, effective count/width and saturating miss count.
  always_comb begin
    arm_rise     = arm_i & ~arm_prev_q;
    eff_count    = (cfg_match_count == '0) ? C_ONE : cfg_match_count;
    eff_width_m1 = (cfg_trigger_width == '0) ? '0 : (cfg_trigger_width - W_ONE);
    cnt_inc      = {1'b0, match_cnt_q} + {1'b0, C_ONE};
    fire_hit     = (cnt_inc >= {1'b0, eff_count});
    missed_sat   = (missed_q == 8'hFF) ? missed_q : (missed_q + 8'd1);
  end

  // Next-state and next-register computation for the qualifier FSM.
  always_comb begin
    state_d       = state_q;
    arm_prev_d    = arm_i;
    triggered_d   = triggered_q;
    match_cnt_d   = match_cnt_q;
    missed_d      = missed_q;
    match_score_d = match_score_q;
    best_score_d  = best_score_q;
    width_cnt_d   = width_cnt_q;
    hold_len_d    = hold_len_q;
    hold_cnt_d    = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          state_d       = ST_ARMED;
          triggered_d   = 1'b0;
          match_cnt_d   = '0;
          missed_d      = '0;
          match_score_d = '0;
          best_score_d  = '1;
        end
      end
      ST_ARMED: begin
        // Disarm has priority over a coincident match.
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else if (sad_match_i) begin
          if (sad_score_i < best_score_q) best_score_d = sad_score_i;
          if (fire_hit) begin
            state_d       = ST_FIRE;
            match_cnt_d   = '0;
            match_score_d = sad_score_i;
            triggered_d   = 1'b1;
            width_cnt_d   = eff_width_m1;
            hold_len_d    = cfg_holdoff;
          end else begin
            match_cnt_d = cnt_inc[pCOUNT_WIDTH-1:0];
          end
        end
      end
      ST_FIRE: begin
        if (sad_match_i) missed_d = missed_sat;
        // The pulse always completes; arm_i is only looked at when it ends.
        if (width_cnt_q == '0) begin
          if (!arm_i) begin
            state_d = ST_IDLE;
          end else if (cfg_single_shot) begin
            state_d = ST_DONE;
          end else if (hold_len_q == '0) begin
            state_d = ST_ARMED;
          end else begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = hold_len_q - H_ONE;
          end
        end else begin
          width_cnt_d = width_cnt_q - W_ONE;
        end
      end
      ST_HOLDOFF: begin
        if (sad_match_i) missed_d = missed_sat;
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          hold_cnt_d = hold_cnt_q - H_ONE;
        end
      end
      ST_DONE: begin
        if (!arm_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    trigger_d = (state_d == ST_FIRE);
    armed_d   = (state_d == ST_ARMED);
  end

  // State and status registers; reset clears everything asynchronously.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      arm_prev_q    <= 1'b0;
      trigger_q     <= 1'b0;
      armed_q       <= 1'b0;
      triggered_q   <= 1'b0;
      match_cnt_q   <= '0;
      missed_q      <= '0;
      match_score_q <= '0;
      best_score_q  <= '1;
      width_cnt_q   <= '0;
      hold_len_q    <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      arm_prev_q    <= arm_prev_d;
      trigger_q     <= trigger_d;
      armed_q       <= armed_d;
      triggered_q   <= triggered_d;
      match_cnt_q   <= match_cnt_d;
      missed_q      <= missed_d;
      match_score_q <= match_score_d;
      best_score_q  <= best_score_d;
      width_cnt_q   <= width_cnt_d;
      hold_len_q    <= hold_len_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign trigger_o     = trigger_q;
  assign armed_o       = armed_q;
  assign triggered_o   = triggered_q;
  assign match_cnt_o   = match_cnt_q;
  assign missed_o      = missed_q;
  assign match_score_o = match_score_q;
  assign best_score_o  = best_score_q;

endmodule

// File: tb/tb_sad_trigger_qualifier.sv
// Bench for sad_trigger_qualifier: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model built from remaining-cycle counters.
module tb_sad_trigger_qualifier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_i;
  logic        sad_match_i;
  logic [31:0] sad_score_i;
  logic [7:0]  cfg_match_count;
  logic [7:0]  cfg_trigger_width;
  logic [15:0] cfg_holdoff;
  logic        cfg_single_shot;
  logic        trigger_o;
  logic        armed_o;
  logic        triggered_o;
  logic [7:0]  match_cnt_o;
  logic [7:0]  missed_o;
  logic [31:0] match_score_o;
  logic [31:0] best_score_o;

  always #5 clk = ~clk;

  sad_trigger_qualifier dut (
    .clk_adc          (clk),
    .reset_n          (rst_n),
    .arm_i            (arm_i),
    .sad_match_i      (sad_match_i),
    .sad_score_i      (sad_score_i),
    .cfg_match_count  (cfg_match_count),
    .cfg_trigger_width(cfg_trigger_width),
    .cfg_holdoff      (cfg_holdoff),
    .cfg_single_shot  (cfg_single_shot),
    .trigger_o        (trigger_o),
    .armed_o          (armed_o),
    .triggered_o      (triggered_o),
    .match_cnt_o      (match_cnt_o),
    .missed_o         (missed_o),
    .match_score_o    (match_score_o),
    .best_score_o     (best_score_o)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the trigger is high while pulse cycles remain,
  // holdoff is a count of remaining quiet cycles, armed/done are flags.
  bit          m_prev, m_armed, m_done, m_trig_st;
  int          m_pulse, m_hold, m_hold_len, m_cnt, m_missed, ec, ew;
  logic [31:0] m_score, m_best;
  bit          rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; m_armed = 0; m_done = 0; m_trig_st = 0;
      m_pulse = 0; m_hold = 0; m_hold_len = 0; m_cnt = 0; m_missed = 0;
      m_score = 0; m_best = 32'hFFFF_FFFF;
    end else begin
      ec   = (cfg_match_count == 0) ? 1 : int'(cfg_match_count);
      ew   = (cfg_trigger_width == 0) ? 1 : int'(cfg_trigger_width);
      rise = arm_i && !m_prev;
      if (m_pulse > 0) begin
        if (sad_match_i && m_missed < 255) m_missed++;
        m_pulse--;
        if (m_pulse == 0) begin
          if (!arm_i) ;
          else if (cfg_single_shot) m_done = 1;
          else if (m_hold_len == 0) m_armed = 1;
          else m_hold = m_hold_len;
        end
      end else if (m_hold > 0) begin
        if (sad_match_i && m_missed < 255) m_missed++;
        if (!arm_i) m_hold = 0;
        else begin
          m_hold--;
          if (m_hold == 0) m_armed = 1;
        end
      end else if (m_done) begin
        if (!arm_i) m_done = 0;
      end else if (m_armed) begin
        if (!arm_i) m_armed = 0;
        else if (sad_match_i) begin
          if (sad_score_i < m_best) m_best = sad_score_i;
          if (m_cnt + 1 >= ec) begin
            m_pulse = ew; m_hold_len = int'(cfg_holdoff); m_cnt = 0;
            m_score = sad_score_i; m_trig_st = 1; m_armed = 0;
          end else m_cnt++;
        end
      end else if (rise) begin
        m_armed = 1; m_trig_st = 0; m_cnt = 0; m_missed = 0;
        m_score = 0; m_best = 32'hFFFF_FFFF;
      end
      m_prev = arm_i;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_trigger",     trigger_o,     m_pulse > 0);
      cmp("m_armed",       armed_o,       m_armed);
      cmp("m_triggered",   triggered_o,   m_trig_st);
      cmp("m_match_cnt",   match_cnt_o,   m_cnt);
      cmp("m_missed",      missed_o,      m_missed);
      cmp("m_match_score", match_score_o, m_score);
      cmp("m_best_score",  best_score_o,  m_best);
    end
  end

  task automatic step(input logic a, input logic m, input logic [31:0] s);
    arm_i = a; sad_match_i = m; sad_score_i = s;
    @(negedge clk);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic set_cfg(input int cnt, input int w, input int h, input bit ss);
    cfg_match_count = 8'(cnt); cfg_trigger_width = 8'(w);
    cfg_holdoff = 16'(h); cfg_single_shot = ss;
  endtask

  initial begin
    rst_n = 1'b0; arm_i = 0; sad_match_i = 0; sad_score_i = 0;
    set_cfg(1, 1, 0, 1'b0);
    repeat (3) @(negedge clk);
    cmp("rst_trigger", trigger_o, 0);
    cmp("rst_best",    best_score_o, 32'hFFFF_FFFF);
    cmp("rst_armed",   armed_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Single-shot, score 37 at cycle 10.
    set_cfg(1, 1, 0, 1'b1);
    go_idle();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'd37);
    cmp("t1_trig_c11", trigger_o, 1);
    cmp("t1_triggered", triggered_o, 1);
    cmp("t1_score", match_score_o, 37);
    step(1'b1, 1'b0, 32'd0);
    cmp("t1_trig_c12", trigger_o, 0);
    cmp("t1_armed_done", armed_o, 0);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 32'd1);
    cmp("t1_no_refire", trigger_o, 0);
    cmp("t1_missed0", missed_o, 0);
    cmp("t1_score_hold", match_score_o, 37);

    // Count 3, width 4, multi-shot, matches 5/9/12.
    set_cfg(3, 4, 0, 1'b0);
    go_idle();
    for (int c = 0; c <= 12; c++) begin
      if (c == 5) step(1'b1, 1'b1, 32'd90);
      else if (c == 9) step(1'b1, 1'b1, 32'd20);
      else if (c == 12) step(1'b1, 1'b1, 32'd55);
      else step(1'b1, 1'b0, 32'd0);
      if (c == 11) cmp("t2_pre_fire", trigger_o, 0);
    end
    cmp("t2_trig_c13", trigger_o, 1);
    cmp("t2_score", match_score_o, 55);
    cmp("t2_best", best_score_o, 20);
    cmp("t2_cnt0", match_cnt_o, 0);
    for (int c = 13; c < 16; c++) step(1'b1, 1'b0, 32'd0);
    cmp("t2_trig_c16", trigger_o, 1);
    step(1'b1, 1'b0, 32'd0);
    cmp("t2_trig_c17", trigger_o, 0);
    cmp("t2_rearmed", armed_o, 1);

    // Count 1, width 2, holdoff 5: matches 10/12/15/19.
    set_cfg(1, 2, 5, 1'b0);
    go_idle();
    for (int c = 0; c <= 19; c++) begin
      step(1'b1, (c == 10 || c == 12 || c == 15 || c == 19), 32'(100 + c));
      if (c == 10) cmp("t3_trig_c11", trigger_o, 1);
      if (c == 16) cmp("t3_hold_c17", armed_o, 0);
      if (c == 17) cmp("t3_armed_c18", armed_o, 1);
    end
    cmp("t3_trig_c20", trigger_o, 1);
    cmp("t3_missed2", missed_o, 2);
    cmp("t3_score", match_score_o, 119);
    step(1'b1, 1'b0, 32'd0);
    cmp("t3_trig_c21", trigger_o, 1);
    step(1'b1, 1'b0, 32'd0);
    cmp("t3_trig_c22", trigger_o, 0);

    // Match on the arm_rise cycle, then disarm coincident with a match.
    set_cfg(1, 1, 0, 1'b0);
    go_idle();
    step(1'b1, 1'b1, 32'd5);
    cmp("t4_armed", armed_o, 1);
    cmp("t4_no_fire", triggered_o, 0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'd6);
    cmp("t4_disarm_trig", trigger_o, 0);
    cmp("t4_disarm_armed", armed_o, 0);
    cmp("t4_best", best_score_o, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'd0);
    cmp("t4_still_quiet", triggered_o, 0);

    // Reset in the middle of a pulse.
    set_cfg(1, 8, 0, 1'b0);
    go_idle();
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'd99);
    cmp("t5_fire", trigger_o, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("t5_trig_async", trigger_o, 0);
    cmp("t5_triggered", triggered_o, 0);
    cmp("t5_score", match_score_o, 0);
    cmp("t5_best", best_score_o, 32'hFFFF_FFFF);
    cmp("t5_missed", missed_o, 0);
    cmp("t5_cnt", match_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    go_idle();

    // Zero count/width behave as 1/1; then saturate missed in a long holdoff.
    set_cfg(0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'd3);
    cmp("t6_trig", trigger_o, 1);
    step(1'b1, 1'b0, 32'd0);
    cmp("t6_width1", trigger_o, 0);
    cmp("t6_rearm", armed_o, 1);
    set_cfg(1, 1, 400, 1'b0);
    step(1'b1, 1'b1, 32'd1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 32'd1);
    cmp("t6_missed_sat", missed_o, 255);
    go_idle();

    // Randomized traffic, checked only by the model.
    arm_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        set_cfg($urandom_range(0, 4), $urandom_range(0, 5),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6),
                ($urandom_range(0, 5) == 0));
      step(($urandom_range(0, 39) == 0) ? ~arm_i : arm_i,
           ($urandom_range(0, 2) == 0), $urandom);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sad_trigger_qualifier.md
Name: sad_trigger_qualifier

Overview:
- Sits directly downstream of the SAD matcher in the clk_adc domain.
- Consumes its per-sample match pulse and SAD score, and applies the arm, Nth-match, pulse-width, holdoff and single-shot rules.
- Drives the qualified trigger to the capture logic and exposes sticky status and score registers for the USB register block.

Parameters:
pSCORE_WIDTH, 32, width of the SAD score from the matcher (matches the SAD threshold width).
pHOLDOFF_WIDTH, 16, width of the holdoff counter and configuration.
pCOUNT_WIDTH, 8, width of the match-count configuration and counter.
pWIDTH_WIDTH, 8, width of the trigger pulse-width configuration.

Ports:
clk_adc  in  1  sample clock, the only clock.
reset_n  in  1  asynchronous active-low reset.
arm_i  in  1  arm level, already synchronised to clk_adc.
sad_match_i  in  1  one-cycle pulse: SAD score at or below threshold.
sad_score_i  in  pSCORE_WIDTH  score, valid when sad_match_i=1.
cfg_match_count  in  pCOUNT_WIDTH  fire on the Nth match; 0 is treated as 1.
cfg_trigger_width  in  pWIDTH_WIDTH  trigger_o high time in cycles; 0 is treated as 1.
cfg_holdoff  in  pHOLDOFF_WIDTH  cycles after a pulse during which matches are ignored.
cfg_single_shot  in  1  1 = fire once per arm.
trigger_o  out  1  qualified trigger.
armed_o  out  1  high in ARMED.
triggered_o  out  1  sticky: fired since the last arm.
match_cnt_o  out  pCOUNT_WIDTH  matches counted toward the next fire.
missed_o  out  8  saturating count of matches ignored in FIRE or HOLDOFF.
match_score_o  out  pSCORE_WIDTH  score of the match that caused the latest fire.
best_score_o  out  pSCORE_WIDTH  minimum score seen on matches counted while ARMED.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE.
  - All outputs 0, except best_score_o = all ones.
  - arm edge register cleared.
- arm_rise is a registered edge: arm_i=1 this cycle and 0 the previous cycle.
- IDLE:
  - On arm_rise: go to ARMED next cycle.
  - Also on arm_rise: clear triggered_o, match_cnt_o, missed_o and match_score_o; set best_score_o to all ones.
  - A match in the arm_rise cycle is ignored.
- ARMED, on sad_match_i=1:
  - best_score_o <= min(best_score_o, sad_score_i).
  - If match_cnt_o+1 >= eff_count: trigger_o=1 from the next edge, match_cnt_o <= 0, match_score_o <= sad_score_i, triggered_o <= 1, go to FIRE.
  - Otherwise match_cnt_o increments.
  - Latency from a match pulse to trigger_o high is exactly 1 clock.
- FIRE:
  - trigger_o stays high for exactly eff_width cycles.
  - Then: if cfg_single_shot=1, go to DONE. Else if cfg_holdoff=0, go to ARMED. Else go to HOLDOFF.
  - Matches in FIRE increment missed_o, saturating at 255.
- HOLDOFF:
  - Lasts exactly cfg_holdoff cycles, counted from the first cycle after trigger_o falls, then go to ARMED.
  - Matches in HOLDOFF increment missed_o, saturating.
- DONE: outputs hold and matches are ignored (missed_o is not counted).
- Disarm (arm_i=0):
  - From ARMED, HOLDOFF or DONE: go to IDLE next cycle.
  - From FIRE: finish the pulse at its full width, then go to IDLE.
  - Status registers keep their values in IDLE until the next arm_rise.
- Config changes:
  - cfg_* are sampled live.
  - eff_width and holdoff length are latched on entry to FIRE, so a mid-pulse config change does not alter the current pulse.
- Simultaneous disarm and match in ARMED: disarm wins, and no fire occurs.
- Back-to-back matches with cfg_match_count=1, holdoff=0, width=1, multi-shot: minimum period between fires is 2 cycles (FIRE, then ARMED). A match arriving during FIRE counts as missed.
- Reset mid-operation: immediate return to the reset state. trigger_o drops asynchronously.

Test Plan:
- Count=1, width=1, single-shot; arm; match with score=37 at cycle 10 -> trigger_o high only in cycle 11; triggered_o=1; match_score_o=37; state DONE; later matches do not fire and missed_o stays 0.
- Count=3, width=4, multi-shot, holdoff=0; matches at cycles 5, 9 and 12 (scores 90, 20, 55) -> trigger_o high cycles 13-16; match_score_o=55; best_score_o=20; match_cnt_o back to 0.
- Count=1, width=2, holdoff=5, multi-shot; matches at cycles 10, 12, 15 and 19 -> fire on the cycle-10 match; cycles 12 and 15 counted as missed (missed_o=2); cycle-19 match fires again (trigger_o high cycles 20-21).
- Match in the arm_rise cycle -> ignored. Disarm in the same cycle as a match while ARMED -> no trigger, state IDLE.
- reset_n low during FIRE -> trigger_o 0 immediately; all status registers 0; best_score_o all ones.
- cfg_match_count=0 and cfg_trigger_width=0 -> behaves as 1/1. 300 matches in holdoff -> missed_o saturates at 255.
